// File: rtl/falc56_bus_ctrl.sv
// FALC56 8-bit Intel-mode bus sequencer with round-robin WB/DEFSM arbitration.
// Latency: request sampled in IDLE, ACK after SETUP+STROBE+HOLD edges; pins registered.
// Backpressure: requesters hold REQ/STB until their one-cycle ACK; no abort once granted.
module falc56_bus_ctrl #(
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 3
) (
  input  logic        PHY_CLK33_I,
  input  logic        PHY_RST_I,
  input  logic [31:0] WB_ADD_I,
  input  logic [31:0] WB_DATA_I,
  output logic [31:0] WB_DATA_O,
  input  logic        WB_STB_I,
  input  logic        WB_WE_I,
  output logic        WB_ACK_O,
  input  logic [7:0]  F56_DEFSM_BADD_I,
  input  logic [7:0]  F56_DEFSM_DATA_I,
  input  logic        F56_DEFSM_REQ_I,
  input  logic        F56_DEFSM_WE_I,
  output logic        F56_DEFSM_ACK_O,
  output logic [7:0]  F56_DEFSM_DATA_O,
  output logic [7:0]  F56_BADD_O,
  output logic [7:0]  F56_DATA_O,
  output logic        F56_DATA_OE_O,
  input  logic [7:0]  F56_DATA_I,
  output logic        F56_CSn_O,
  output logic        F56_RDn_O,
  output logic        F56_WRn_O,
  input  logic        F56_INTn_I,
  output logic        F56_INT_O
);

  // Counter reload values: each timed state lasts N cycles, so load N-1.
  localparam logic [3:0] SETUP_L  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_L = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_L   = 4'(HOLD_CYC - 1);
  localparam logic [3:0] RECOV_L  = 4'(RECOV_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_RECOVER
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_df_q, last_df_d;   // 1 = DEFSM granted last, so WB preferred next
  logic        gnt_wb_q, gnt_wb_d;
  logic        we_q, we_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  logic [7:0]  rdlat_q, rdlat_d;
  logic [7:0]  wb_rdat_q, wb_rdat_d;
  logic [7:0]  df_rdat_q, df_rdat_d;
  logic        wb_ack_q, wb_ack_d;
  logic        df_ack_q, df_ack_d;
  logic        csn_q, csn_d;
  logic        rdn_q, rdn_d;
  logic        wrn_q, wrn_d;
  logic        oe_q, oe_d;
  logic        int_s1_q, int_s2_q;
  logic        grant_wb;
  logic        in_access;

  // Upper Wishbone bits carry nothing for an 8-bit chip bus.
  logic unused_hi;
  assign unused_hi = ^{WB_ADD_I[31:8], WB_DATA_I[31:8]};

  // Next-state, arbitration, latching and pin decode from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_df_d = last_df_q;
    gnt_wb_d  = gnt_wb_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdlat_d   = rdlat_q;
    wb_rdat_d = wb_rdat_q;
    df_rdat_d = df_rdat_q;
    wb_ack_d  = 1'b0;
    df_ack_d  = 1'b0;
    grant_wb  = WB_STB_I && (!F56_DEFSM_REQ_I || last_df_q);
    case (state_q)
      ST_IDLE: begin
        if (WB_STB_I || F56_DEFSM_REQ_I) begin
          gnt_wb_d  = grant_wb;
          last_df_d = !grant_wb;
          addr_d    = grant_wb ? WB_ADD_I[7:0]  : F56_DEFSM_BADD_I;
          wdat_d    = grant_wb ? WB_DATA_I[7:0] : F56_DEFSM_DATA_I;
          we_d      = grant_wb ? WB_WE_I        : F56_DEFSM_WE_I;
          state_d   = ST_SETUP;
          cnt_d     = SETUP_L;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_L;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_L;
          rdlat_d = F56_DATA_I;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d  = ST_RECOVER;
          cnt_d    = RECOV_L;
          wb_ack_d = gnt_wb_q;
          df_ack_d = !gnt_wb_q;
          if (!we_q) begin
            if (gnt_wb_q) wb_rdat_d = rdlat_q;
            else          df_rdat_d = rdlat_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == 4'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    in_access = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    csn_d = !in_access;
    oe_d  = in_access && we_d;
    rdn_d = !((state_d == ST_STROBE) && !we_d);
    wrn_d = !((state_d == ST_STROBE) && we_d);
  end

  // State, datapath and registered pin drivers; interrupt double-flop sync.
  always_ff @(posedge PHY_CLK33_I) begin
    if (PHY_RST_I) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      last_df_q <= 1'b1;
      gnt_wb_q  <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdat_q    <= 8'h00;
      rdlat_q   <= 8'h00;
      wb_rdat_q <= 8'h00;
      df_rdat_q <= 8'h00;
      wb_ack_q  <= 1'b0;
      df_ack_q  <= 1'b0;
      csn_q     <= 1'b1;
      rdn_q     <= 1'b1;
      wrn_q     <= 1'b1;
      oe_q      <= 1'b0;
      int_s1_q  <= 1'b1;
      int_s2_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_df_q <= last_df_d;
      gnt_wb_q  <= gnt_wb_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      rdlat_q   <= rdlat_d;
      wb_rdat_q <= wb_rdat_d;
      df_rdat_q <= df_rdat_d;
      wb_ack_q  <= wb_ack_d;
      df_ack_q  <= df_ack_d;
      csn_q     <= csn_d;
      rdn_q     <= rdn_d;
      wrn_q     <= wrn_d;
      oe_q      <= oe_d;
      int_s1_q  <= F56_INTn_I;
      int_s2_q  <= int_s1_q;
    end
  end

  assign WB_DATA_O        = {24'h0, wb_rdat_q};
  assign WB_ACK_O         = wb_ack_q;
  assign F56_DEFSM_ACK_O  = df_ack_q;
  assign F56_DEFSM_DATA_O = df_rdat_q;
  assign F56_BADD_O       = addr_q;
  assign F56_DATA_O       = wdat_q;
  assign F56_DATA_OE_O    = oe_q;
  assign F56_CSn_O        = csn_q;
  assign F56_RDn_O        = rdn_q;
  assign F56_WRn_O        = wrn_q;
  assign F56_INT_O        = !int_s2_q;

endmodule
